// File: rtl/alu_rr_sequencer_if.sv
// Request/response bundle for alu_rr_sequencer.
//   master: requester/consumer side (drives requests, rsp_ready)
//   slave : sequencer side (drives req_ready, rsp_*, busy)
// Signals:
//   req_valid[N], req_ready[N] : per-requester handshake
//   req_op[2N], req_a[8N], req_b[8N] : packed per-requester payload
//   rsp_valid, rsp_ready : result handshake
//   rsp_id[ID_W], rsp_y[9] : owner of the result and the 9-bit result
//   busy : high while an operation is executing or awaiting hand-off
interface alu_rr_sequencer_if #(
  parameter int unsigned N    = 2,
  parameter int unsigned ID_W = 1
) ();
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [2*N-1:0]  req_op;
  logic [8*N-1:0]  req_a;
  logic [8*N-1:0]  req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [ID_W-1:0] rsp_id;
  logic [8:0]      rsp_y;
  logic            busy;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y, busy
  );
endinterface

// File: rtl/alu_rr_sequencer.sv
// Round-robin shared bit-serial ALU (add/sub/AND/XOR, 9-bit result).
// One operation in flight: accept in IDLE, 8 bit-serial steps in EXEC (LSB first),
// then hold the result in RESP until the consumer takes it.
// Ports:
//   clk    : clock, posedge
//   rstn   : synchronous active-low reset
//   io_bus : alu_rr_sequencer_if slave modport (requests in, response out)
module alu_rr_sequencer #(
  parameter int unsigned N    = 2,
  parameter int unsigned ID_W = 1
) (
  input logic              clk,
  input logic              rstn,
  alu_rr_sequencer_if.slave io_bus
);

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpAnd = 2'b10;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          r_state, w_state_next;

  logic [ID_W-1:0] w_gnt, w_idx;
  logic            w_gnt_vld;
  logic [1:0]      w_op;
  logic [7:0]      w_a, w_b;
  logic [N-1:0]    w_req_ready;
  logic            w_rsp_valid, w_busy;

  logic [1:0]      r_op;
  logic [7:0]      r_a, r_b;   // shifted right each step; bit 0 is the current bit
  logic [7:0]      r_acc;      // result bits shift in from the top
  logic [2:0]      r_cnt;
  logic            r_c;        // carry for add, borrow for sub
  logic [8:0]      r_rsp_y;
  logic [ID_W-1:0] r_rsp_id;
  logic [ID_W-1:0] r_last;

  logic            w_abit, w_bbit, w_ybit, w_cnext;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_idx     = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      w_idx = ID_W'((32'(r_last) + off) % N);
      if (!w_gnt_vld && io_bus.req_valid[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_idx;
      end
    end
  end

  // Payload of the granted requester.
  always_comb begin
    w_op = '0;
    w_a  = '0;
    w_b  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (w_gnt == ID_W'(k)) begin
        w_op = io_bus.req_op[2*k +: 2];
        w_a  = io_bus.req_a[8*k +: 8];
        w_b  = io_bus.req_b[8*k +: 8];
      end
    end
  end

  // One ripple stage of the selected op.
  always_comb begin
    w_abit = r_a[0];
    w_bbit = r_b[0];
    case (r_op)
      OpAdd: begin
        w_ybit  = w_abit ^ w_bbit ^ r_c;
        w_cnext = (w_abit & w_bbit) | (w_bbit & r_c) | (r_c & w_abit);
      end
      OpSub: begin
        w_ybit  = w_abit ^ w_bbit ^ r_c;
        w_cnext = (~w_abit & w_bbit) | (~(w_abit ^ w_bbit) & r_c);
      end
      OpAnd: begin
        w_ybit  = w_abit & w_bbit;
        w_cnext = 1'b0;
      end
      default: begin
        w_ybit  = w_abit ^ w_bbit;
        w_cnext = 1'b0;
      end
    endcase
  end

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_gnt_vld) w_state_next = StExec;
      StExec:  if (r_cnt == 3'd7) w_state_next = StResp;
      StResp:  if (io_bus.rsp_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    w_req_ready = '0;
    if (r_state == StIdle && w_gnt_vld) w_req_ready[w_gnt] = 1'b1;
    w_rsp_valid = (r_state == StResp);
    w_busy      = (r_state != StIdle);
  end

  // Datapath.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_c      <= 1'b0;
      r_rsp_y  <= '0;
      r_rsp_id <= '0;
      r_last   <= ID_W'(N - 1);
    end else begin
      case (r_state)
        StIdle: begin
          if (w_gnt_vld) begin
            r_op     <= w_op;
            r_a      <= w_a;
            r_b      <= w_b;
            r_rsp_id <= w_gnt;
            r_cnt    <= '0;
            r_c      <= 1'b0;
          end
        end
        StExec: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_cnext;
          r_acc <= {w_ybit, r_acc[7:1]};
          r_cnt <= r_cnt + 3'd1;
          // Publish only the completed result; bits 0..6 sit in r_acc[7:1].
          if (r_cnt == 3'd7) r_rsp_y <= {w_cnext, w_ybit, r_acc[7:1]};
        end
        StResp: begin
          if (io_bus.rsp_ready) r_last <= r_rsp_id;
        end
        default: ;
      endcase
    end
  end

  assign io_bus.req_ready = w_req_ready;
  assign io_bus.rsp_valid = w_rsp_valid;
  assign io_bus.busy      = w_busy;
  assign io_bus.rsp_y     = r_rsp_y;
  assign io_bus.rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed bench for alu_rr_sequencer (N=2): ops, round-robin, backpressure, abort.
module tb_alu_rr_sequencer;

  logic clk = 1'b0;
  logic rstn;

  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] prev_y = '0;

  always #5 clk = ~clk;

  alu_rr_sequencer_if #(.N(2), .ID_W(1)) bus ();

  alu_rr_sequencer #(.N(2), .ID_W(1)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .io_bus (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int k, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b);
    bus.req_op[2*k +: 2] = op;
    bus.req_a[8*k +: 8]  = a;
    bus.req_b[8*k +: 8]  = b;
    bus.req_valid[k]     = 1'b1;
    #1;
  endtask

  // Returns at the negedge right after the accept edge, with valid dropped.
  task automatic wait_accept(input int k);
    int cyc = 0;
    while (!bus.req_ready[k] && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("accept_seen", 32'(bus.req_ready[k]), 32'd1);
    @(negedge clk);
    bus.req_valid[k] = 1'b0;
    check_eq("busy_after_accept", 32'(bus.busy), 32'd1);
  endtask

  // Called at the negedge after the accept edge; expects rsp_valid 8 edges later.
  task automatic wait_rsp(input logic [8:0] exp_y, input logic exp_id);
    int lat = 0;
    while (!bus.rsp_valid && lat < 30) begin
      if (lat == 4) check_eq("y_held_in_exec", 32'(bus.rsp_y), 32'(prev_y));
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 32'(lat), 32'd8);
    check_eq("rsp_y", 32'(bus.rsp_y), 32'(exp_y));
    check_eq("rsp_id", 32'(bus.rsp_id), 32'(exp_id));
    check_eq("busy_in_resp", 32'(bus.busy), 32'd1);
    prev_y = exp_y;
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check_eq("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
    check_eq("busy_drop", 32'(bus.busy), 32'd0);
  endtask

  task automatic run_op(input int k, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [8:0] exp_y);
    issue(k, op, a, b);
    wait_accept(k);
    wait_rsp(exp_y, k[0]);
    handshake();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    prev_y = '0;
  endtask

  initial begin
    logic [8:0] cont_y [2];
    logic       grants [4];
    int ng;
    int nr;
    bit just_acc;

    rstn          = 1'b0;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    do_reset();

    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_rsp_y", 32'(bus.rsp_y), 32'd0);
    check_eq("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);

    // Basic ops.
    run_op(0, 2'b00, 8'h83, 8'hE2, 9'h165);
    run_op(1, 2'b01, 8'h02, 8'h03, 9'h1FF);
    run_op(1, 2'b01, 8'h05, 8'h03, 9'h002);
    run_op(0, 2'b10, 8'h62, 8'h0F, 9'h002);
    run_op(0, 2'b11, 8'h71, 8'h2A, 9'h05B);

    // Contention: both valid from reset release, consumer always ready.
    rstn = 1'b0;
    bus.req_op    = {2'b11, 2'b00};
    bus.req_a     = {8'hFF, 8'h01};
    bus.req_b     = {8'h0F, 8'h01};
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rstn   = 1'b1;
    prev_y = '0;
    cont_y[0] = 9'h002;
    cont_y[1] = 9'h0F0;
    ng = 0;
    nr = 0;
    just_acc = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (bus.req_ready != 2'b00) begin
        check_eq("ready_onehot", 32'($countones(bus.req_ready)), 32'd1);
        grants[ng] = bus.req_ready[1];
        ng++;
        just_acc = 1'b1;
      end else if (just_acc) begin
        check_eq("cont_busy_exec", 32'(bus.busy), 32'd1);
        just_acc = 1'b0;
      end
      if (bus.rsp_valid) begin
        check_eq("cont_busy_resp", 32'(bus.busy), 32'd1);
        check_eq("cont_rsp_id", 32'(bus.rsp_id), 32'(nr % 2));
        check_eq("cont_rsp_y", 32'(bus.rsp_y), 32'(cont_y[nr % 2]));
        nr++;
      end
      if (ng == 4) break;
      @(negedge clk);
    end
    check_eq("cont_grants_seen", 32'(ng), 32'd4);
    @(negedge clk);
    bus.req_valid = 2'b00;
    for (int i = 0; i < 4; i++) check_eq("grant_order", 32'(grants[i]), 32'(i % 2));
    prev_y = 9'h002;
    wait_rsp(9'h0F0, 1'b1);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check_eq("cont_rsp_done", 32'(bus.rsp_valid), 32'd0);

    // Backpressure with a pending request from requester 1.
    issue(0, 2'b00, 8'h10, 8'h20);
    wait_accept(0);
    issue(1, 2'b01, 8'h05, 8'h03);
    wait_rsp(9'h030, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("bp_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("bp_y", 32'(bus.rsp_y), 32'h030);
      check_eq("bp_id", 32'(bus.rsp_id), 32'd0);
      check_eq("bp_no_accept", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check_eq("bp_ready_in_resp", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check_eq("bp_rsp_done", 32'(bus.rsp_valid), 32'd0);
    check_eq("bp_pending_grant", 32'(bus.req_ready), 32'b10);
    wait_accept(1);
    wait_rsp(9'h002, 1'b1);
    handshake();

    // Carry out of bit 7; leaves requester 0 as last grant.
    run_op(0, 2'b00, 8'hFF, 8'h01, 9'h100);

    // Reset mid-EXEC at counter 4.
    issue(0, 2'b00, 8'h12, 8'h34);
    wait_accept(0);
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("abort_rsp_y", 32'(bus.rsp_y), 32'd0);
    bus.req_valid = 2'b11;
    #1;
    check_eq("abort_next_grant", 32'(bus.req_ready), 32'b01);
    @(negedge clk);
    bus.req_valid = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
